kitchen_timer_ctrl: RTL
=======================

Name: kitchen_timer_ctrl

Overview:
Countdown controller for the kitchen timer. It derives a one-second enable from the 50 MHz system clock (20 ns period) and sequences a BCD MM:SS countdown through set, run, pause and alarm phases. Button inputs arrive as debounced single-cycle pulses from upstream logic. The MM:SS outputs feed the display multiplexer, and the alarm output drives the buzzer.

Parameters:
TICKS_PER_SEC, 50000000, number of clk cycles per one-second tick (benches use 4)
ALARM_SECS, 30, number of ticks the alarm stays asserted before automatic return to IDLE

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
btn_start  input  1  one-cycle pulse; toggles start/pause, and acknowledges the alarm
btn_min  input  1  one-cycle pulse; adds one minute while in IDLE
btn_sec  input  1  one-cycle pulse; adds one second while in IDLE
btn_clear  input  1  one-cycle pulse; zeroes the time and returns to IDLE
min_bcd  output  8  minutes as two BCD digits, 00-99
sec_bcd  output  8  seconds as two BCD digits, 00-59
state  output  2  IDLE=0, RUN=1, PAUSE=2, ALARM=3
running  output  1  high when state==RUN
alarm  output  1  high when state==ALARM
tick  output  1  one-cycle pulse when the prescaler wraps

Behaviour:
- All outputs are registered. While rst is high, or on its assertion: state=IDLE, min_bcd=00, sec_bcd=00, prescaler=0, alarm counter=0, running=0, alarm=0, tick=0. Reset asserted mid-count aborts immediately and returns to these values.
- Prescaler: counts 0..TICKS_PER_SEC-1 only in RUN and ALARM.
  - On wrap it produces tick=1 for one cycle.
  - In PAUSE it holds its value. In IDLE it is cleared.
  - First tick after IDLE->RUN occurs exactly TICKS_PER_SEC cycles after the btn_start edge.
- Button priority within one cycle: btn_clear > btn_start > (btn_min, btn_sec). Pulses not listed for the current state are ignored.
- IDLE:
  - btn_min: min +1 BCD, 99 wraps to 00.
  - btn_sec: sec +1 BCD, 59 wraps to 00, no carry into minutes.
  - btn_min and btn_sec in the same cycle: both apply.
  - btn_clear: 00:00.
  - btn_start: goes to RUN if time != 00:00, otherwise ignored.
- RUN:
  - On tick, decrement MM:SS. Seconds 00 borrows, giving sec=59 and min-1.
  - A tick that produces 00:00 moves to ALARM on the same edge; the display shows 00:00.
  - btn_start: goes to PAUSE.
  - btn_start and tick in the same cycle: the decrement still applies. If the result is 00:00, ALARM wins over PAUSE.
  - btn_clear: goes to IDLE with 00:00, even if a tick occurs in the same cycle.
- PAUSE:
  - Time is frozen.
  - btn_start: goes to RUN, and the prescaler resumes from its held value.
  - btn_clear: goes to IDLE with 00:00.
- ALARM:
  - alarm=1. Entry clears the alarm counter.
  - Each tick increments the counter. When the counter reaches ALARM_SECS, go to IDLE.
  - btn_start or btn_clear: goes to IDLE immediately.
  - Time remains 00:00.
- BCD digits never leave 0-9. The seconds tens digit never exceeds 5.

Test Plan:
- Reset: assert rst mid-RUN at 01:30 -> min_bcd=00, sec_bcd=00, state=0, alarm=0, tick=0 immediately, without waiting for a clk edge.
- Set wrap: in IDLE send 61 btn_sec pulses and 100 btn_min pulses -> sec_bcd=8'h01, min_bcd=8'h00. btn_start at 00:00 -> state stays 0.
- Countdown with borrow (TICKS_PER_SEC=4): set 01:01, then btn_start -> 01:00 four cycles later, 00:59 four cycles after that. 61 ticks after start -> state=3, alarm=1.
- Pause/resume: at 00:05 with the prescaler at 2, btn_start -> state=2, time frozen for 20 cycles. btn_start again -> next decrement 2 cycles later, giving 00:04.
- Alarm timeout and ack (ALARM_SECS=3): alarm stays high for exactly 12 cycles, then state=0. In a second run, btn_start during ALARM -> state=0 and alarm=0 on the next edge.
- Simultaneous events: btn_start coinciding with the tick that reaches 00:00 -> state=3, not 2. btn_clear together with btn_start in RUN -> state=0, 00:00.

Source files
------------

// File: rtl/kitchen_timer_ctrl.sv
// Kitchen timer countdown controller: one-second prescaler plus a BCD MM:SS
// sequencer with set, run, pause and alarm phases.
module kitchen_timer_ctrl #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int ALARM_SECS    = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       btn_clear,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] state,
  output logic       running,
  output logic       alarm,
  output logic       tick
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_ALARM = 2'd3;

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

  // Two-digit BCD step; max_tens bounds the tens digit (5 for seconds, 9 for minutes).
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] max_tens);
    if (v[3:0] == 4'd9)
      bcd_inc = (v[7:4] == max_tens) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    else
      bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [3:0] max_tens);
    if (v[3:0] == 4'd0)
      bcd_dec = (v[7:4] == 4'd0) ? {max_tens, 4'd9} : {v[7:4] - 4'd1, 4'd9};
    else
      bcd_dec = {v[7:4], v[3:0] - 4'd1};
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic [1:0]    state_d;
  logic [7:0]    min_d, sec_d;
  logic [7:0]    min_dec, sec_dec;
  logic          wrap;

  assign wrap    = ((state == S_RUN) || (state == S_ALARM)) && (presc_q == PRESC_MAX);
  assign sec_dec = bcd_dec(sec_bcd, 4'd5);
  assign min_dec = (sec_bcd == 8'h00) ? bcd_dec(min_bcd, 4'd9) : min_bcd;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d = state;
    min_d   = min_bcd;
    sec_d   = sec_bcd;
    acnt_d  = acnt_q;
    case (state)
      S_IDLE: begin
        if (btn_clear) begin
          min_d = 8'h00;
          sec_d = 8'h00;
        end else if (btn_start) begin
          if ((min_bcd != 8'h00) || (sec_bcd != 8'h00)) state_d = S_RUN;
        end else begin
          if (btn_min) min_d = bcd_inc(min_bcd, 4'd9);
          if (btn_sec) sec_d = bcd_inc(sec_bcd, 4'd5);
        end
      end
      S_RUN: begin
        if (btn_clear) begin
          state_d = S_IDLE;
          min_d   = 8'h00;
          sec_d   = 8'h00;
        end else begin
          if (btn_start) state_d = S_PAUSE;
          if (wrap) begin
            min_d = min_dec;
            sec_d = sec_dec;
            // Reaching 00:00 overrides a simultaneous pause request.
            if ((min_dec == 8'h00) && (sec_dec == 8'h00)) begin
              state_d = S_ALARM;
              acnt_d  = '0;
            end
          end
        end
      end
      S_PAUSE: begin
        if (btn_clear) begin
          state_d = S_IDLE;
          min_d   = 8'h00;
          sec_d   = 8'h00;
        end else if (btn_start) begin
          state_d = S_RUN;
        end
      end
      default: begin
        if (btn_clear || btn_start) begin
          state_d = S_IDLE;
        end else if (wrap) begin
          if (acnt_q == ALARM_LAST) state_d = S_IDLE;
          else                      acnt_d  = acnt_q + AW'(1);
        end
      end
    endcase
  end

  // The prescaler freezes on the pause edge and on the resume edge, so a resumed
  // count reaches its next tick after exactly the remaining cycles.
  always_comb begin
    presc_d = presc_q;
    if (state_d == S_IDLE)
      presc_d = '0;
    else if (wrap)
      presc_d = '0;
    else if (((state == S_RUN) && (state_d == S_RUN)) || (state == S_ALARM))
      presc_d = presc_q + PW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      min_bcd <= 8'h00;
      sec_bcd <= 8'h00;
      presc_q <= '0;
      acnt_q  <= '0;
      running <= 1'b0;
      alarm   <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= state_d;
      min_bcd <= min_d;
      sec_bcd <= sec_d;
      presc_q <= presc_d;
      acnt_q  <= acnt_d;
      running <= (state_d == S_RUN);
      alarm   <= (state_d == S_ALARM);
      tick    <= wrap;
    end
  end

endmodule
